// File: rtl/iq_framer_pkg.sv
// Shared types and header layout for the IQ sample framer.
package iq_framer_pkg;

   localparam logic [15:0] HDR_MARKER     = 16'hA55A;
   localparam int          HDR_MARKER_LSB = 48;
   localparam int          HDR_SEQ_LSB    = 32;
   localparam int          HDR_LO_LSB     = 0;

   typedef enum logic [2:0] {IDLE, CHECK, HEADER, STREAM, DROP} state_t;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] q;
   } iq_pair_t;

endpackage

// File: rtl/iq_sample_framer_if.sv
// Sample-side and FIFO-write-side buses of the IQ sample framer.
interface iq_sample_if;
   logic [31:0] i_data;
   logic        i_valid;
   logic [31:0] q_data;
   logic        q_valid;

   modport master (output i_data, i_valid, q_data, q_valid);
   modport slave  (input  i_data, i_valid, q_data, q_valid);
endinterface

interface iq_fifo_wr_if;
   logic [63:0] fifo_data;
   logic        fifo_we;
   logic [10:0] fifo_wrcnt;
   logic        fifo_full;

   modport master (output fifo_data, fifo_we, input  fifo_wrcnt, fifo_full);
   modport slave  (input  fifo_data, fifo_we, output fifo_wrcnt, fifo_full);
endinterface

// File: rtl/iq_pair_align.sv
// Pairs independently strobed I and Q samples; discards lone or repeated samples with skew_err.
module iq_pair_align
   import iq_framer_pkg::*;
#(
   parameter int PAIR_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [31:0] i_data,
   input  logic        i_valid,
   input  logic [31:0] q_data,
   input  logic        q_valid,
   output logic        pair_valid,
   output iq_pair_t    pair_data,
   output logic        skew_err
);

   localparam int AGE_W = (PAIR_TIMEOUT > 0) ? $clog2(PAIR_TIMEOUT + 1) : 1;

   logic             i_full, q_full;
   logic [31:0]      i_hold, q_hold;
   logic [AGE_W-1:0] age;
   logic             rep, timeout;

   // A pair forms on the edge where the later sample arrives; the earlier one comes from its hold.
   always_comb begin
      pair_valid  = !clear && (i_valid || i_full) && (q_valid || q_full);
      pair_data.i = i_valid ? i_data : i_hold;
      pair_data.q = q_valid ? q_data : q_hold;
      rep         = (i_valid && i_full) || (q_valid && q_full);
      timeout     = (i_full || q_full) && !i_valid && !q_valid && (age == AGE_W'(PAIR_TIMEOUT));
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         i_full   <= 1'b0;
         q_full   <= 1'b0;
         i_hold   <= '0;
         q_hold   <= '0;
         age      <= '0;
         skew_err <= 1'b0;
      end else begin
         skew_err <= rep || timeout;
         if (pair_valid || timeout) begin
            i_full <= 1'b0;
            q_full <= 1'b0;
            age    <= '0;
         end else begin
            if (i_valid) begin
               i_full <= 1'b1;
               i_hold <= i_data;
            end
            if (q_valid) begin
               q_full <= 1'b1;
               q_hold <= q_data;
            end
            // age restarts on every fresh sample, including an overwrite
            if (i_valid || q_valid || !(i_full || q_full))
               age <= '0;
            else
               age <= age + 1'b1;
         end
      end
   end

endmodule

// File: rtl/iq_sample_framer.sv
// Frames paired IQ samples into header-prefixed blocks, dropping whole blocks when the FIFO lacks room.
// Optional build macro IQ_FRAMER_TIMESTAMP_EN: header low word carries a free-running cycle count.
module iq_sample_framer
   import iq_framer_pkg::*;
#(
   parameter int BLOCKSIZE    = 1024,
   parameter int FIFO_DEPTH   = 2048,
   parameter int PAIR_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   iq_sample_if.slave         adc,
   iq_fifo_wr_if.master       fifo,
   output logic [15:0]        drop_cnt,
   output logic               skew_err,
   output logic               ovf,
   output logic               block_done
);

   localparam int CNT_W = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;

   state_t           state, state_nx;
   logic             pair_valid;
   iq_pair_t         pair_data, pend, src;
   logic             pend_vld, pend_ld;
   logic [15:0]      seq;
   logic [CNT_W-1:0] pair_cnt, pair_cnt_nx;
   logic             wr_req, take, cnt_last, room_ok, done_nx, seq_inc, drop_inc;
   logic [63:0]      wr_word, hdr, data_r;
   logic [31:0]      hdr_lo;
   logic             we_r;

   iq_pair_align #(.PAIR_TIMEOUT(PAIR_TIMEOUT)) u_align (
      .clk        (clk),
      .rst        (rst),
      .clear      (state == IDLE),
      .i_data     (adc.i_data),
      .i_valid    (adc.i_valid),
      .q_data     (adc.q_data),
      .q_valid    (adc.q_valid),
      .pair_valid (pair_valid),
      .pair_data  (pair_data),
      .skew_err   (skew_err)
   );

`ifdef IQ_FRAMER_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge clk) begin
      if (rst) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 32'd1;
   end

   assign hdr_lo = ts_cnt;
`else
   assign hdr_lo = {16'd0, drop_cnt};
`endif

   always_comb begin
      hdr = '0;
      hdr[HDR_MARKER_LSB +: 16] = HDR_MARKER;
      hdr[HDR_SEQ_LSB    +: 16] = seq;
      hdr[HDR_LO_LSB     +: 32] = hdr_lo;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      wr_req      = 1'b0;
      wr_word     = hdr;
      done_nx     = 1'b0;
      seq_inc     = 1'b0;
      drop_inc    = 1'b0;
      pend_ld     = 1'b0;
      pair_cnt_nx = pair_cnt;
      room_ok     = (FIFO_DEPTH - int'(fifo.fifo_wrcnt)) >= (BLOCKSIZE + 1);
      // a pair caught during CHECK waits one deep and goes out ahead of any new one
      take        = pair_valid || pend_vld;
      src         = pend_vld ? pend : pair_data;
      cnt_last    = (pair_cnt == CNT_W'(BLOCKSIZE - 1));
      if (!enable) begin
         state_nx    = IDLE;
         pair_cnt_nx = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx    = CHECK;
               pair_cnt_nx = '0;
            end
            CHECK: begin
               pend_ld = pair_valid;
               if (room_ok) begin
                  state_nx = HEADER;
                  wr_req   = 1'b1;
               end else begin
                  state_nx = DROP;
               end
            end
            HEADER, STREAM: begin
               state_nx = STREAM;
               if (take) begin
                  wr_req      = 1'b1;
                  wr_word     = src;
                  pair_cnt_nx = cnt_last ? '0 : pair_cnt + 1'b1;
                  if (cnt_last) begin
                     done_nx  = 1'b1;
                     seq_inc  = 1'b1;
                     state_nx = CHECK;
                  end
               end
            end
            DROP: begin
               if (take) begin
                  pair_cnt_nx = cnt_last ? '0 : pair_cnt + 1'b1;
                  if (cnt_last) begin
                     done_nx  = 1'b1;
                     seq_inc  = 1'b1;
                     drop_inc = 1'b1;
                     state_nx = CHECK;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_r       <= 1'b0;
         data_r     <= '0;
         block_done <= 1'b0;
         ovf        <= 1'b0;
         seq        <= '0;
         drop_cnt   <= '0;
         pair_cnt   <= '0;
         pend_vld   <= 1'b0;
         pend       <= '0;
      end else begin
         we_r       <= wr_req && !fifo.fifo_full;
         block_done <= done_nx;
         pair_cnt   <= pair_cnt_nx;
         pend_vld   <= pend_ld;
         if (wr_req)                   data_r   <= wr_word;
         if (wr_req && fifo.fifo_full) ovf      <= 1'b1;
         if (seq_inc)                  seq      <= seq + 16'd1;
         if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         if (pend_ld)                  pend     <= pair_data;
      end
   end

   assign fifo.fifo_we   = we_r;
   assign fifo.fifo_data = data_r;

endmodule

// File: tb/tb_iq_sample_framer.sv
// Directed self-checking bench for iq_sample_framer with BLOCKSIZE=4.
module tb_iq_sample_framer;

   localparam int BS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] drop_cnt;
   logic        skew_err, ovf, block_done;

   iq_sample_if  sif();
   iq_fifo_wr_if fif();

   iq_sample_framer #(.BLOCKSIZE(BS), .FIFO_DEPTH(2048), .PAIR_TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .adc        (sif),
      .fifo       (fif),
      .drop_cnt   (drop_cnt),
      .skew_err   (skew_err),
      .ovf        (ovf),
      .block_done (block_done)
   );

   always #5 clk = ~clk;

   int          nchk = 0;
   int          nfail = 0;
   int          done_cnt = 0;
   int          skew_cnt = 0;
   logic [63:0] wr_q[$];
   logic [31:0] ts_q[$];
   logic [31:0] cyc = '0;

   always @(posedge clk) cyc <= rst ? 32'd0 : cyc + 32'd1;

   always @(posedge clk) begin
      #2;
      if (fif.fifo_we === 1'b1) begin
         wr_q.push_back(fif.fifo_data);
         ts_q.push_back(cyc - 32'd1);
      end
      if (block_done === 1'b1) done_cnt++;
      if (skew_err === 1'b1) skew_cnt++;
   end

   function automatic logic [63:0] wr_at(int idx);
      if (idx < wr_q.size()) return wr_q[idx];
      return 'x;
   endfunction

   function automatic logic [63:0] exp_hdr(int idx, logic [15:0] s, logic [15:0] drops);
      logic [31:0] lo;
`ifdef IQ_FRAMER_TIMESTAMP_EN
      lo = (idx < ts_q.size()) ? ts_q[idx] : 32'hDEAD_BEEF;
      if (drops == 16'hFFFF) lo = 32'hDEAD_BEEF;
`else
      lo = {16'd0, drops};
      if (idx < 0) lo = 32'hDEAD_BEEF;
`endif
      return {16'hA55A, s, lo};
   endfunction

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(logic iv, logic qv, logic [31:0] id, logic [31:0] qd);
      sif.i_valid = iv;
      sif.q_valid = qv;
      sif.i_data  = id;
      sif.q_data  = qd;
      @(negedge clk);
      sif.i_valid = 1'b0;
      sif.q_valid = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      enable = 1'b0;
      fif.fifo_full = 1'b0;
      fif.fifo_wrcnt = '0;
      idle(2);
      rst = 1'b0;
      wr_q.delete();
      ts_q.delete();
      done_cnt = 0;
      skew_cnt = 0;
   endtask

   task automatic test_reset;
      idle(3);
      nchk++; if (fif.fifo_we !== 1'b0)   begin nfail++; $display("FAIL reset_we: got %b want 0", fif.fifo_we); end
      nchk++; if (fif.fifo_data !== '0)   begin nfail++; $display("FAIL reset_data: got %h want 0", fif.fifo_data); end
      nchk++; if (block_done !== 1'b0)    begin nfail++; $display("FAIL reset_done: got %b want 0", block_done); end
      nchk++; if (skew_err !== 1'b0)      begin nfail++; $display("FAIL reset_skew: got %b want 0", skew_err); end
      nchk++; if (ovf !== 1'b0)           begin nfail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      nchk++; if (drop_cnt !== 16'd0)     begin nfail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      rst = 1'b0;
      idle(5);
      nchk++; if (wr_q.size() !== 0)      begin nfail++; $display("FAIL idle_writes: got %0d want 0", wr_q.size()); end
   endtask

   task automatic test_clean_block;
      logic [63:0] exp;
      do_reset();
      enable = 1'b1;
      idle(2);
      for (int k = 0; k < BS; k++) begin
         strobe(1'b1, 1'b1, 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k));
         if (k < BS - 1) idle(7);
      end
      idle(4);
      enable = 1'b0;
      idle(3);
      nchk++; if (wr_q.size() !== BS + 2) begin nfail++; $display("FAIL clean_count: got %0d want %0d", wr_q.size(), BS + 2); end
      exp = exp_hdr(0, 16'd0, 16'd0);
      nchk++; if (wr_at(0) !== exp) begin nfail++; $display("FAIL clean_hdr0: got %h want %h", wr_at(0), exp); end
      for (int k = 0; k < BS; k++) begin
         exp = {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)};
         nchk++; if (wr_at(k + 1) !== exp) begin nfail++; $display("FAIL clean_pair%0d: got %h want %h", k, wr_at(k + 1), exp); end
      end
      exp = exp_hdr(BS + 1, 16'd1, 16'd0);
      nchk++; if (wr_at(BS + 1) !== exp) begin nfail++; $display("FAIL clean_hdr1: got %h want %h", wr_at(BS + 1), exp); end
      nchk++; if (done_cnt !== 1) begin nfail++; $display("FAIL clean_done: got %0d want 1", done_cnt); end
   endtask

   // continues from the clean block, so seq is already 1
   task automatic test_abort;
      logic [63:0] exp;
      wr_q.delete();
      ts_q.delete();
      done_cnt = 0;
      enable = 1'b1;
      idle(2);
      strobe(1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0001);
      idle(7);
      strobe(1'b1, 1'b1, 32'hAAAA_0002, 32'hBBBB_0002);
      idle(2);
      enable = 1'b0;
      idle(3);
      nchk++; if (wr_q.size() !== 3) begin nfail++; $display("FAIL abort_count: got %0d want 3", wr_q.size()); end
      exp = exp_hdr(0, 16'd1, 16'd0);
      nchk++; if (wr_at(0) !== exp) begin nfail++; $display("FAIL abort_hdr: got %h want %h", wr_at(0), exp); end
      nchk++; if (wr_at(2) !== 64'hAAAA_0002_BBBB_0002) begin nfail++; $display("FAIL abort_pair1: got %h want aaaa0002bbbb0002", wr_at(2)); end
      nchk++; if (done_cnt !== 0) begin nfail++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
      enable = 1'b1;
      idle(2);
      enable = 1'b0;
      idle(2);
      exp = exp_hdr(3, 16'd1, 16'd0);
      nchk++; if (wr_at(3) !== exp) begin nfail++; $display("FAIL abort_rehdr: got %h want %h", wr_at(3), exp); end
   endtask

   task automatic test_skew;
      int early;
      do_reset();
      enable = 1'b1;
      idle(2);
      // I at edge 0, Q at edge 10
      strobe(1'b1, 1'b0, 32'h0000_00A1, 32'h0);
      idle(9);
      strobe(1'b0, 1'b1, 32'h0, 32'h0000_00B1);
      idle(4);
      // lone I: must survive edges 1..15, discarded at edge 16
      strobe(1'b1, 1'b0, 32'h0000_00C1, 32'h0);
      early = 0;
      for (int k = 1; k <= 15; k++) begin
         idle(1);
         if (skew_err !== 1'b0) early++;
      end
      nchk++; if (early !== 0) begin nfail++; $display("FAIL skew_early: got %0d pulses want 0", early); end
      idle(1);
      nchk++; if (skew_err !== 1'b1) begin nfail++; $display("FAIL skew_pulse16: got %b want 1", skew_err); end
      idle(1);
      nchk++; if (skew_err !== 1'b0) begin nfail++; $display("FAIL skew_width: got %b want 0", skew_err); end
      idle(4);
      // partner exactly on edge 15 still pairs
      strobe(1'b1, 1'b0, 32'h0000_00D1, 32'h0);
      idle(14);
      strobe(1'b0, 1'b1, 32'h0, 32'h0000_00E1);
      idle(4);
      // repeat I overwrites the held one
      strobe(1'b1, 1'b0, 32'h0000_00F1, 32'h0);
      idle(4);
      strobe(1'b1, 1'b0, 32'h0000_00F2, 32'h0);
      idle(4);
      strobe(1'b0, 1'b1, 32'h0, 32'h0000_00F3);
      idle(3);
      enable = 1'b0;
      idle(2);
      nchk++; if (wr_q.size() !== 4) begin nfail++; $display("FAIL skew_count: got %0d want 4", wr_q.size()); end
      nchk++; if (wr_at(1) !== 64'h0000_00A1_0000_00B1) begin nfail++; $display("FAIL skew_pair10: got %h want 000000a1000000b1", wr_at(1)); end
      nchk++; if (wr_at(2) !== 64'h0000_00D1_0000_00E1) begin nfail++; $display("FAIL skew_pair15: got %h want 000000d1000000e1", wr_at(2)); end
      nchk++; if (wr_at(3) !== 64'h0000_00F2_0000_00F3) begin nfail++; $display("FAIL skew_repeat: got %h want 000000f2000000f3", wr_at(3)); end
      nchk++; if (skew_cnt !== 2) begin nfail++; $display("FAIL skew_pulses: got %0d want 2", skew_cnt); end
   endtask

   task automatic test_overflow_drop;
      logic [63:0] exp;
      do_reset();
      fif.fifo_wrcnt = 11'd2044;
      enable = 1'b1;
      idle(2);
      fif.fifo_wrcnt = 11'd0;
      for (int k = 0; k < BS; k++) begin
         strobe(1'b1, 1'b1, 32'h3000_0000 + 32'(k), 32'h4000_0000 + 32'(k));
         if (k < BS - 1) idle(7);
      end
      idle(4);
      enable = 1'b0;
      idle(2);
      nchk++; if (wr_q.size() !== 1) begin nfail++; $display("FAIL drop_count: got %0d want 1", wr_q.size()); end
      exp = exp_hdr(0, 16'd1, 16'd1);
      nchk++; if (wr_at(0) !== exp) begin nfail++; $display("FAIL drop_hdr: got %h want %h", wr_at(0), exp); end
      nchk++; if (drop_cnt !== 16'd1) begin nfail++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
      nchk++; if (done_cnt !== 1) begin nfail++; $display("FAIL drop_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_full;
      do_reset();
      enable = 1'b1;
      idle(2);
      strobe(1'b1, 1'b1, 32'h5000_0000, 32'h6000_0000);
      idle(7);
      fif.fifo_full = 1'b1;
      strobe(1'b1, 1'b1, 32'h5000_0001, 32'h6000_0001);
      nchk++; if (fif.fifo_we !== 1'b0) begin nfail++; $display("FAIL full_we: got %b want 0", fif.fifo_we); end
      nchk++; if (ovf !== 1'b1) begin nfail++; $display("FAIL full_ovf: got %b want 1", ovf); end
      fif.fifo_full = 1'b0;
      idle(7);
      strobe(1'b1, 1'b1, 32'h5000_0002, 32'h6000_0002);
      idle(3);
      nchk++; if (ovf !== 1'b1) begin nfail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
      nchk++; if (wr_at(2) !== 64'h5000_0002_6000_0002) begin nfail++; $display("FAIL full_continue: got %h want 5000000260000002", wr_at(2)); end
      // reset lands on the same edge as a completing pair
      rst = 1'b1;
      enable = 1'b0;
      sif.i_valid = 1'b1; sif.q_valid = 1'b1;
      sif.i_data = 32'h5000_0003; sif.q_data = 32'h6000_0003;
      @(negedge clk);
      sif.i_valid = 1'b0; sif.q_valid = 1'b0;
      nchk++; if (fif.fifo_we !== 1'b0) begin nfail++; $display("FAIL rst_we: got %b want 0", fif.fifo_we); end
      nchk++; if (fif.fifo_data !== '0) begin nfail++; $display("FAIL rst_data: got %h want 0", fif.fifo_data); end
      nchk++; if (ovf !== 1'b0) begin nfail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
      rst = 1'b0;
      idle(4);
      nchk++; if (wr_q.size() !== 3) begin nfail++; $display("FAIL rst_writes: got %0d want 3", wr_q.size()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.i_valid = 1'b0;
      sif.q_valid = 1'b0;
      sif.i_data = '0;
      sif.q_data = '0;
      fif.fifo_full = 1'b0;
      fif.fifo_wrcnt = '0;
      @(negedge clk);
      test_reset();
      test_clean_block();
      test_abort();
      test_skew();
      test_overflow_drop();
      test_reset_full();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
